// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: merges pipeline writeback and a queued load/IO stream into the register file write port, with bypass lookup.
// Optional REGFILE_WSCHED_STATS_EN adds saturating squash_cnt and stall_cnt outputs.
module regfile_write_scheduler #(
  parameter int WIDTH = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_valid,
  input  logic [ADDRESSWIDTH-1:0]     wb_addr,
  input  logic [WIDTH-1:0]            wb_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [ADDRESSWIDTH-1:0]     ld_addr,
  input  logic [WIDTH-1:0]            ld_data,
  output logic                        we3,
  output logic [ADDRESSWIDTH-1:0]     wa3,
  output logic [WIDTH-1:0]            wd3,
  input  logic [ADDRESSWIDTH-1:0]     ra1,
  input  logic [ADDRESSWIDTH-1:0]     ra2,
  output logic                        hit1,
  output logic                        hit2,
  output logic [WIDTH-1:0]            fwd1,
  output logic [WIDTH-1:0]            fwd2,
  output logic [$clog2(DEPTH):0]      pending
`ifdef REGFILE_WSCHED_STATS_EN
  ,
  output logic [15:0]                 squash_cnt,
  output logic [15:0]                 stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [ADDRESSWIDTH-1:0] RO = '1;
  logic [ADDRESSWIDTH-1:0] q_addr [DEPTH];
  logic [WIDTH-1:0] q_data [DEPTH];
  logic [DEPTH-1:0] q_valid, squash, pop_mask, push_mask;
  logic [AW-1:0] wr_ptr, rd_ptr, idx;
  logic [PW-1:0] count;
  logic wb_take, push, pop, head_live;
  assign wb_take = wb_valid && wb_addr != RO;
  assign ld_ready = count < PW'(DEPTH);
  assign push = ld_valid && ld_ready && ld_addr != RO;
  assign pop = !wb_take && count != '0;
  assign head_live = pop && q_valid[rd_ptr];
  assign pop_mask = pop ? DEPTH'(1) << rd_ptr : '0;
  assign push_mask = push ? DEPTH'(1) << wr_ptr : '0;
  always_comb begin
    squash = '0;
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash[i] = wb_take && q_valid[i] && q_addr[i] == wb_addr;
      pending = pending + PW'(q_valid[i]);
    end
  end
  // Squashed slots keep their place in the ring; only the valid bit drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
      q_valid <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      we3 <= wb_take || head_live;
      wa3 <= wb_take ? wb_addr : head_live ? q_addr[rd_ptr] : wa3;
      wd3 <= wb_take ? wb_data : head_live ? q_data[rd_ptr] : wd3;
      q_valid <= (q_valid & ~squash & ~pop_mask) | push_mask;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + PW'(push) - PW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= ld_addr;
      q_data[wr_ptr] <= ld_data;
    end
  end
  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    idx = '0;
    hit1 = we3 && wa3 == ra1 && ra1 != RO;
    hit2 = we3 && wa3 == ra2 && ra2 != RO;
    fwd1 = hit1 ? wd3 : '0;
    fwd2 = hit2 ? wd3 : '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (q_valid[idx] && q_addr[idx] == ra1 && ra1 != RO) begin
        hit1 = 1'b1;
        fwd1 = q_data[idx];
      end
      if (q_valid[idx] && q_addr[idx] == ra2 && ra2 != RO) begin
        hit2 = 1'b1;
        fwd2 = q_data[idx];
      end
    end
  end
`ifdef REGFILE_WSCHED_STATS_EN
  logic [PW-1:0] n_sq;
  logic [16:0] sq_sum;
  always_comb begin
    n_sq = '0;
    for (int i = 0; i < DEPTH; i++) n_sq = n_sq + PW'(squash[i]);
  end
  assign sq_sum = {1'b0, squash_cnt} + 17'(n_sq);
  always_ff @(posedge clk) begin
    if (rst) begin
      squash_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      squash_cnt <= sq_sum[16] ? 16'hFFFF : sq_sum[15:0];
      stall_cnt <= (ld_valid && !ld_ready && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: directed and random stimulus checked against a queue-based model of the write scheduler.
module tb_regfile_write_scheduler;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst;
  logic wb_valid, ld_valid, ld_ready, we3, hit1, hit2;
  logic [3:0] wb_addr, ld_addr, wa3, ra1, ra2;
  logic [15:0] wb_data, ld_data, wd3, fwd1, fwd2;
  logic [2:0] pending;
`ifdef REGFILE_WSCHED_STATS_EN
  logic [15:0] squash_cnt, stall_cnt;
`endif
  always #5 clk = ~clk;

  regfile_write_scheduler #(.WIDTH(16), .ADDRESSWIDTH(4), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
    .pending(pending)
`ifdef REGFILE_WSCHED_STATS_EN
    , .squash_cnt(squash_cnt), .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {logic [3:0] a; logic [15:0] d; bit v;} ent_t;
  ent_t q[$];
  bit m_we;
  logic [3:0] m_wa;
  logic [15:0] m_wd;
  int m_sq, m_st;
  int compared = 0, mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [3:0] ra, output bit h, output logic [15:0] f);
    h = 0;
    f = '0;
    if (ra != 4'hF) begin
      if (m_we && m_wa == ra) begin h = 1; f = m_wd; end
      foreach (q[i]) if (q[i].v && q[i].a == ra) begin h = 1; f = q[i].d; end
    end
  endtask

  task automatic check_comb();
    int p = 0;
    bit h;
    logic [15:0] f;
    foreach (q[i]) if (q[i].v) p++;
    chk("ld_ready", 32'(ld_ready), 32'(q.size() < D));
    chk("pending", 32'(pending), 32'(p));
    lookup(ra1, h, f);
    chk("hit1", 32'(hit1), 32'(h));
    chk("fwd1", 32'(fwd1), 32'(f));
    lookup(ra2, h, f);
    chk("hit2", 32'(hit2), 32'(h));
    chk("fwd2", 32'(fwd2), 32'(f));
  endtask

  task automatic check_out();
    chk("we3", 32'(we3), 32'(m_we));
    chk("wa3", 32'(wa3), 32'(m_wa));
    chk("wd3", 32'(wd3), 32'(m_wd));
`ifdef REGFILE_WSCHED_STATS_EN
    chk("squash_cnt", 32'(squash_cnt), 32'(m_sq));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_st));
`endif
  endtask

  task automatic step(input bit wv, input logic [3:0] wa, input logic [15:0] wd,
                      input bit lv, input logic [3:0] la, input logic [15:0] ldd,
                      input logic [3:0] r1, input logic [3:0] r2);
    bit rdy, take;
    ent_t e;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    ld_valid = lv; ld_addr = la; ld_data = ldd;
    ra1 = r1; ra2 = r2;
    #1;
    check_comb();
    rdy = q.size() < D;
    take = wv && wa != 4'hF;
    if (take) begin
      foreach (q[i]) if (q[i].v && q[i].a == wa) begin
        q[i].v = 0;
        if (m_sq < 16'hFFFF) m_sq++;
      end
      m_we = 1; m_wa = wa; m_wd = wd;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = e.v;
      if (e.v) begin m_wa = e.a; m_wd = e.d; end
    end else m_we = 0;
    if (lv && rdy && la != 4'hF) q.push_back('{la, ldd, 1'b1});
    if (lv && !rdy && m_st < 16'hFFFF) m_st++;
    @(posedge clk);
    #1;
    check_out();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [3:0] r1, input logic [3:0] r2);
    for (int i = 0; i < n; i++) step(0, 4'd0, 16'd0, 0, 4'd0, 16'd0, r1, r2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wb_valid = 0; ld_valid = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_we = 0; m_wa = '0; m_wd = '0; m_sq = 0; m_st = 0;
    check_out();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    wb_valid = 0; wb_addr = '0; wb_data = '0;
    ld_valid = 0; ld_addr = '0; ld_data = '0;
    ra1 = '0; ra2 = '0;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 16; i++) idle(1, 4'(i), 4'(15 - i));
    step(1, 4'd3, 16'h00AA, 0, 4'd0, 16'd0, 4'd3, 4'd0);
    idle(2, 4'd3, 4'd0);
    for (int i = 1; i <= 4; i++) step(0, 4'd0, 16'd0, 1, 4'(i), 16'(16'h0011 * i), 4'(i), 4'd1);
    idle(4, 4'd4, 4'd2);
    for (int i = 0; i < 6; i++) step(1, 4'd5, 16'(16'h5000 + i), 1, 4'(8 + i), 16'(16'h0800 + i), 4'd5, 4'd8);
    idle(6, 4'd9, 4'd11);
    step(0, 4'd0, 16'd0, 1, 4'd7, 16'h1111, 4'd7, 4'd7);
    step(1, 4'd7, 16'h2222, 0, 4'd0, 16'd0, 4'd7, 4'd7);
    idle(3, 4'd7, 4'd7);
    step(1, 4'd6, 16'hAAAA, 1, 4'd6, 16'hBBBB, 4'd6, 4'd6);
    idle(3, 4'd6, 4'd6);
    step(0, 4'd0, 16'd0, 1, 4'd15, 16'hDEAD, 4'd15, 4'd2);
    step(0, 4'd0, 16'd0, 1, 4'd2, 16'h0BEE, 4'd15, 4'd2);
    idle(3, 4'd15, 4'd2);
    step(1, 4'd15, 16'h1234, 0, 4'd0, 16'd0, 4'd15, 4'd15);
    idle(1, 4'd15, 4'd0);
    for (int i = 0; i < 5; i++) step(1, 4'd1, 16'(16'h7000 + i), 1, 4'(i), 16'(16'h0900 + i), 4'(i), 4'd1);
    do_reset();
    idle(2, 4'd0, 4'd1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 4, 4'($urandom_range(0, 15)), 16'($urandom),
           $urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), 16'($urandom),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    idle(6, 4'd0, 4'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Initiator side of the register-file write port: owns we3/wa3/wd3 and sequences all register writes into the single write port.
- Merges two write sources:
  - pipeline writeback: highest priority, never stalled;
  - multi-cycle load/IO unit: valid/ready, buffered in a small FIFO.
- Provides bypass lookup so decode sees pending, not-yet-committed values.
- Sits between the writeback stage / load unit and the register file.

Parameters:
- WIDTH, 16, data width of each register
- ADDRESSWIDTH, 4, register address width; all-ones address is the read-only startIO slot
- DEPTH, 4, load/IO write FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- wb_valid  in  1  pipeline writeback request this cycle
- wb_addr  in  ADDRESSWIDTH  pipeline destination register
- wb_data  in  WIDTH  pipeline write data
- ld_valid  in  1  load/IO unit write request
- ld_ready  out  1  FIFO can accept (handshake when ld_valid & ld_ready)
- ld_addr  in  ADDRESSWIDTH  load/IO destination register
- ld_data  in  WIDTH  load/IO write data
- we3  out  1  register file write enable
- wa3  out  ADDRESSWIDTH  register file write address
- wd3  out  WIDTH  register file write data
- ra1, ra2  in  ADDRESSWIDTH  decode read addresses, for bypass lookup
- hit1, hit2  out  1  a pending write exists for ra1/ra2
- fwd1, fwd2  out  WIDTH  value ra1/ra2 will hold once pending writes drain
- pending  out  clog2(DEPTH)+1  valid FIFO entries

Behaviour:
- Reset (rst=1 at clk edge):
  - we3=0, wa3=0, wd3=0;
  - FIFO cleared, all entry valids 0, pending=0, ld_ready=1.
  - Reset mid-drain discards queued writes.
- Output stage is registered; one-cycle latency from request to we3.
- Per-cycle arbitration:
  - wb_valid with wb_addr != all-ones: next we3=1, wa3=wb_addr, wd3=wb_data. FIFO is not popped.
  - Otherwise, if the FIFO head is valid: pop it, drive it next cycle.
  - Otherwise: we3=0. wa3/wd3 hold their previous values.
- FIFO:
  - ld_ready = (occupancy < DEPTH). It is combinational from registered state and does not depend on ld_valid.
  - Push on ld_valid & ld_ready. Push and pop may occur in the same cycle.
  - Pointers wrap modulo DEPTH.
- Read-only slot:
  - wb write to all-ones address: ignored, no we3.
  - ld write to all-ones address: handshake completes (ld_ready honoured), entry not stored.
- Squash (ordering):
  - An accepted wb write clears the valid bit of every queued entry with the same address, so the younger pipeline value is not overwritten later.
  - Squashed entries still occupy slots. On reaching the head they pop without asserting we3; that cycle is not given to any other entry.
  - An ld push in the same cycle as a wb write to the same address is stored valid (the ld is younger).
- pending counts valid (unsquashed) entries only.
- Bypass, combinational (same for ra2/hit2/fwd2):
  - hit1=1 if the registered output stage (we3 & wa3==ra1) or any valid FIFO entry matches ra1.
  - fwd1 priority: youngest matching valid FIFO entry, then the output stage.
  - When hit1=0: fwd1=0.
  - ra1 all-ones never hits.
- Starvation:
  - ld entries wait while wb_valid is continuously asserted. This is accepted.
  - With FIFO full, ld_ready stays 0 until a pop.

Optional Feature:
- Macro: REGFILE_WSCHED_STATS_EN.
- Defined: adds outputs squash_cnt [15:0] and stall_cnt [15:0].
  - squash_cnt increments per entry invalidated.
  - stall_cnt increments each cycle ld_valid=1 and ld_ready=0.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then idle: we3=0, ld_ready=1, pending=0, hit1=hit2=0 for all ra.
- wb_valid=1, wb_addr=3, wb_data=16'h00AA for 1 cycle: next cycle we3=1, wa3=3, wd3=16'h00AA; following cycle we3=0.
- Push 4 ld writes (addr 1..4, data 16'h0011..16'h0044) with wb idle:
  - ld_ready=0 after the 4th push if no pop has occurred;
  - writes then appear on we3 in order 1,2,3,4, one per cycle.
- Hold wb_valid=1 (addr 5) for 6 cycles while ld pushes to fill: FIFO fills, ld_ready=0, no ld write issued; after wb drops, queued entries drain in order.
- Queue ld addr 7 data 16'h1111, then wb addr 7 data 16'h2222:
  - final register write sequence contains 16'h2222 and no later write of 16'h1111;
  - pending decrements; squash_cnt=1 when REGFILE_WSCHED_STATS_EN is defined.
- Queue ld addr 15 and ld addr 2 data 16'h0BEE with ra1=15, ra2=2:
  - addr 15 is never written and hit1=0;
  - hit2=1, fwd2=16'h0BEE until that write leaves the output stage.
